cond_unit: RTL and testbench

Conditional-execution unit for the ARM datapath: the consumer of the ALU's N/Z/C/V flags. It holds the architectural flags register and evaluates each instruction's 4-bit condition field against the flags. It gates the instruction's PC, register and memory write enables. Because ALU flags arrive one cycle after issue, it tracks pending flag writes and either forwards them or stalls. It sits between the decoder (control signals) and the ALU (flags), feeding write enables to the register file, data memory and PC mux.

---
 rtl/arm_pkg.sv | 30 +++
 rtl/cond_check.sv | 40 ++++
 rtl/cond_unit.sv | 75 +++++++
 tb/tb_cond_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM condition codes, flag indices and flag type
package arm_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition evaluator
// Ports: cond (4-bit condition field), flags ({N,Z,C,V}), pass (condition holds).
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM conditional-execution unit with flags register and flag hazard handling
// Optional feature macro: COND_FLAG_FWD_EN (forward in-flight ALU flags instead of stalling).
// Ports: clk, reset_n (sync, active-low); valid_i, cond_i, flag_w_i, pcs_i, reg_w_i, mem_w_i
// from the decoder; alu_flags_i from the ALU one cycle after issue; gated pcsrc_o,
// reg_write_o, mem_write_o; cond_ex_o; stall_o; flags_o; skip_cnt_o.
module cond_unit
  import arm_pkg::*;
#(
  parameter int SKIP_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [3:0]        cond_i,
  input  logic [1:0]        flag_w_i,
  input  logic              pcs_i,
  input  logic              reg_w_i,
  input  logic              mem_w_i,
  input  logic [3:0]        alu_flags_i,
  output logic              pcsrc_o,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic              cond_ex_o,
  output logic              stall_o,
  output logic [3:0]        flags_o,
  output logic [SKIP_W-1:0] skip_cnt_o
);

  // pend[1] covers N,Z and pend[0] covers C,V of a write whose ALU result arrives this cycle
  logic [1:0] pend;
  logic [3:0] eff_flags;
  logic       pass;
  logic       accepted;

`ifdef COND_FLAG_FWD_EN
  always_comb begin
    eff_flags = flags_o;
    if (pend[1]) eff_flags[FLAG_N:FLAG_Z] = alu_flags_i[FLAG_N:FLAG_Z];
    if (pend[0]) eff_flags[FLAG_C:FLAG_V] = alu_flags_i[FLAG_C:FLAG_V];
  end
  assign stall_o = 1'b0;
`else
  // Without forwarding the held instruction re-evaluates next cycle on the drained flags;
  // pend never reloads during a stall, so the stall is a single cycle.
  assign eff_flags = flags_o;
  assign stall_o   = reset_n & valid_i & (pend != 2'b00);
`endif

  cond_check u_cond_check (
    .cond  (cond_i),
    .flags (eff_flags),
    .pass  (pass)
  );

  assign accepted    = reset_n & valid_i & !stall_o;
  assign cond_ex_o   = accepted & pass;
  assign pcsrc_o     = pcs_i & cond_ex_o;
  assign reg_write_o = reg_w_i & cond_ex_o;
  assign mem_write_o = mem_w_i & cond_ex_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend       <= 2'b00;
      flags_o    <= 4'b0000;
      skip_cnt_o <= '0;
    end else begin
      pend <= flag_w_i & {2{cond_ex_o}};
      if (pend[1]) flags_o[FLAG_N:FLAG_Z] <= alu_flags_i[FLAG_N:FLAG_Z];
      if (pend[0]) flags_o[FLAG_C:FLAG_V] <= alu_flags_i[FLAG_C:FLAG_V];
      if (accepted && !pass && (skip_cnt_o != {SKIP_W{1'b1}}))
        skip_cnt_o <= skip_cnt_o + SKIP_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - directed self-checking bench for cond_unit
module tb_cond_unit;

  localparam int SKIP_W = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid_i;
  logic [3:0]        cond_i;
  logic [1:0]        flag_w_i;
  logic              pcs_i, reg_w_i, mem_w_i;
  logic [3:0]        alu_flags_i;
  logic              pcsrc_o, reg_write_o, mem_write_o, cond_ex_o, stall_o;
  logic [3:0]        flags_o;
  logic [SKIP_W-1:0] skip_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_unit #(.SKIP_W(SKIP_W)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_i     (valid_i),
    .cond_i      (cond_i),
    .flag_w_i    (flag_w_i),
    .pcs_i       (pcs_i),
    .reg_w_i     (reg_w_i),
    .mem_w_i     (mem_w_i),
    .alu_flags_i (alu_flags_i),
    .pcsrc_o     (pcsrc_o),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .cond_ex_o   (cond_ex_o),
    .stall_o     (stall_o),
    .flags_o     (flags_o),
    .skip_cnt_o  (skip_cnt_o)
  );

  // Drive one cycle's inputs just after the falling edge; combinational outputs settle by #1.
  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [2:0] req, input logic [3:0] alu);
    @(negedge clk);
    valid_i = v; cond_i = c; flag_w_i = fw;
    pcs_i = req[2]; reg_w_i = req[1]; mem_w_i = req[0];
    alu_flags_i = alu;
    #1;
  endtask

  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(1'b1, 4'hE, 2'b11, 3'b111, 4'hF);
    checks++; if ({pcsrc_o, reg_write_o, mem_write_o, cond_ex_o} !== 4'b0000) begin errors++; $display("FAIL reset_gate got %b want 0000", {pcsrc_o, reg_write_o, mem_write_o, cond_ex_o}); end
    edge_wait();
    drive(1'b1, 4'hE, 2'b11, 3'b111, 4'hF);
    edge_wait();
    checks++; if (flags_o !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags_o); end
    checks++; if (skip_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_skip got %0d want 0", skip_cnt_o); end
    checks++; if (u_dut.pend !== 2'b00) begin errors++; $display("FAIL reset_pend got %b want 00", u_dut.pend); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
    reset_n = 1'b1;
  endtask

  task automatic test_eq_after_reset;
    drive(1'b1, 4'h0, 2'b00, 3'b010, 4'h0);
    checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL eq_reset_regw got %b want 0", reg_write_o); end
    edge_wait();
    checks++; if (skip_cnt_o !== 3'd1) begin errors++; $display("FAIL eq_reset_skip got %0d want 1", skip_cnt_o); end
  endtask

  task automatic test_flag_write;
    drive(1'b1, 4'hE, 2'b11, 3'b000, 4'h0);
    checks++; if (cond_ex_o !== 1'b1) begin errors++; $display("FAIL fw_al_condex got %b want 1", cond_ex_o); end
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'b0100);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fw_idle_stall got %b want 0", stall_o); end
    edge_wait();
    checks++; if (flags_o !== 4'b0100) begin errors++; $display("FAIL fw_flags got %b want 0100", flags_o); end
    drive(1'b1, 4'h0, 2'b00, 3'b001, 4'h0);
    checks++; if (mem_write_o !== 1'b1) begin errors++; $display("FAIL fw_eq_memw got %b want 1", mem_write_o); end
    edge_wait();
  endtask

  task automatic test_ge_hazard;
    drive(1'b1, 4'hE, 2'b11, 3'b000, 4'h0);
    drive(1'b1, 4'hA, 2'b00, 3'b111, 4'b1000);
`ifdef COND_FLAG_FWD_EN
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ge_stall got %b want 0", stall_o); end
    checks++; if (cond_ex_o !== 1'b0) begin errors++; $display("FAIL ge_condex got %b want 0", cond_ex_o); end
    edge_wait();
`else
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL ge_stall got %b want 1", stall_o); end
    checks++; if ({pcsrc_o, reg_write_o, mem_write_o, cond_ex_o} !== 4'b0000) begin errors++; $display("FAIL ge_stall_gate got %b want 0000", {pcsrc_o, reg_write_o, mem_write_o, cond_ex_o}); end
    edge_wait();
    checks++; if (flags_o !== 4'b1000) begin errors++; $display("FAIL ge_drain got %b want 1000", flags_o); end
    drive(1'b1, 4'hA, 2'b00, 3'b111, 4'b0000);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ge_stall_end got %b want 0", stall_o); end
    checks++; if (cond_ex_o !== 1'b0) begin errors++; $display("FAIL ge_held_condex got %b want 0", cond_ex_o); end
    edge_wait();
`endif
    checks++; if (flags_o !== 4'b1000) begin errors++; $display("FAIL ge_flags got %b want 1000", flags_o); end
    checks++; if (skip_cnt_o !== 3'd2) begin errors++; $display("FAIL ge_skip got %0d want 2", skip_cnt_o); end
  endtask

  task automatic test_never;
    drive(1'b1, 4'hF, 2'b11, 3'b111, 4'hF);
    checks++; if ({pcsrc_o, reg_write_o, mem_write_o, cond_ex_o} !== 4'b0000) begin errors++; $display("FAIL nv_gate got %b want 0000", {pcsrc_o, reg_write_o, mem_write_o, cond_ex_o}); end
    edge_wait();
    checks++; if (skip_cnt_o !== 3'd3) begin errors++; $display("FAIL nv_skip got %0d want 3", skip_cnt_o); end
    checks++; if (u_dut.pend !== 2'b00) begin errors++; $display("FAIL nv_pend got %b want 00", u_dut.pend); end
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'hF);
    edge_wait();
    checks++; if (flags_o !== 4'b1000) begin errors++; $display("FAIL nv_flags got %b want 1000", flags_o); end
  endtask

  task automatic test_partial;
    drive(1'b1, 4'hE, 2'b11, 3'b000, 4'h0);
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'b0000);
    edge_wait();
    checks++; if (flags_o !== 4'b0000) begin errors++; $display("FAIL part_clear got %b want 0000", flags_o); end
    drive(1'b1, 4'hE, 2'b10, 3'b000, 4'h0);
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'b1111);
    edge_wait();
    checks++; if (flags_o !== 4'b1100) begin errors++; $display("FAIL part_nz got %b want 1100", flags_o); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 4'hE, 2'b01, 3'b000, 4'h0);
    drive(1'b1, 4'hE, 2'b10, 3'b000, 4'b1110);
    edge_wait();
    checks++; if (flags_o !== 4'b1110) begin errors++; $display("FAIL b2b_cv got %b want 1110", flags_o); end
`ifndef COND_FLAG_FWD_EN
    drive(1'b1, 4'hE, 2'b10, 3'b000, 4'b0000);
    checks++; if (cond_ex_o !== 1'b1) begin errors++; $display("FAIL b2b_held got %b want 1", cond_ex_o); end
`endif
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'b0001);
    edge_wait();
    checks++; if (flags_o !== 4'b0010) begin errors++; $display("FAIL b2b_nz got %b want 0010", flags_o); end
  endtask

  task automatic test_reset_pending;
    drive(1'b1, 4'hE, 2'b11, 3'b000, 4'h0);
    edge_wait();
    checks++; if (u_dut.pend !== 2'b11) begin errors++; $display("FAIL rp_loaded got %b want 11", u_dut.pend); end
    reset_n = 1'b0;
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'b1111);
    edge_wait();
    checks++; if (u_dut.pend !== 2'b00) begin errors++; $display("FAIL rp_pend got %b want 00", u_dut.pend); end
    reset_n = 1'b1;
    drive(1'b0, 4'h0, 2'b00, 3'b000, 4'b1111);
    edge_wait();
    checks++; if (flags_o !== 4'b0000) begin errors++; $display("FAIL rp_flags got %b want 0000", flags_o); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'hF, 2'b00, 3'b000, 4'h0);
      edge_wait();
    end
    checks++; if (skip_cnt_o !== 3'd7) begin errors++; $display("FAIL sat_skip got %0d want 7", skip_cnt_o); end
  endtask

  initial begin
    reset_n = 1'b0; valid_i = 1'b0; cond_i = 4'h0; flag_w_i = 2'b00;
    pcs_i = 1'b0; reg_w_i = 1'b0; mem_w_i = 1'b0; alu_flags_i = 4'h0;
    test_reset();
    test_eq_after_reset();
    test_flag_write();
    test_ge_hazard();
    test_never();
    test_partial();
    test_back_to_back();
    test_reset_pending();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
